// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, presents pc/inst to decode.
// Optional macro IF_TIMEOUT_EN adds a REQ-cycle watchdog that raises fetch_err.
module if_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jCe,
    input  logic [31:0] jAddr,
    input  logic        excpt,
    input  logic [31:0] ejpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_fetch_pc, w_fetch_pc_nx;
    logic [31:0] r_redir_pc, w_redir_pc_nx;
    logic        r_redir_pend, w_redir_pend_nx;
    logic        r_req, w_req_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_inst, w_inst_nx;
    logic        r_vld, w_vld_nx;

    logic [31:0] w_pc_inc;
    logic [31:0] w_sel_raw;
    logic [31:0] w_sel_pc;
    logic        w_redir_hit;
    logic [31:0] w_redir_tgt;

`ifdef IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_err, w_err_nx;
    logic          w_tmo;
    assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    assign w_pc_inc    = r_pc + 32'd4;
    assign w_sel_raw   = excpt ? ejpc : (jCe ? jAddr : w_pc_inc);
    assign w_sel_pc    = {w_sel_raw[31:2], 2'b00};
    // A redirect arriving in the same cycle as the ack still discards that ack's data.
    assign w_redir_hit = r_redir_pend | excpt;
    assign w_redir_tgt = excpt ? {ejpc[31:2], 2'b00} : r_redir_pc;

    always_comb begin
        w_state_nx      = r_state;
        w_fetch_pc_nx   = r_fetch_pc;
        w_redir_pc_nx   = r_redir_pc;
        w_redir_pend_nx = r_redir_pend;
        w_req_nx        = r_req;
        w_addr_nx       = r_addr;
        w_pc_nx         = r_pc;
        w_inst_nx       = r_inst;
        w_vld_nx        = r_vld;
`ifdef IF_TIMEOUT_EN
        w_cnt_nx        = '0;
        w_err_nx        = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                w_state_nx = S_REQ;
                w_req_nx   = 1'b1;
                w_addr_nx  = r_fetch_pc;
            end
            S_REQ: begin
`ifdef IF_TIMEOUT_EN
                w_cnt_nx = r_cnt + 1'b1;
`endif
                if (excpt) begin
                    w_redir_pc_nx   = {ejpc[31:2], 2'b00};
                    w_redir_pend_nx = 1'b1;
                end
                if (imem_ack) begin
                    if (w_redir_hit) begin
                        w_redir_pend_nx = 1'b0;
                        w_fetch_pc_nx   = w_redir_tgt;
                        w_addr_nx       = w_redir_tgt;
`ifdef IF_TIMEOUT_EN
                        w_cnt_nx        = '0;
`endif
                    end else begin
                        w_inst_nx  = imem_rdata;
                        w_pc_nx    = r_fetch_pc;
                        w_vld_nx   = 1'b1;
                        w_req_nx   = 1'b0;
                        w_state_nx = S_HOLD;
                    end
                end
`ifdef IF_TIMEOUT_EN
                else if (w_tmo) begin
                    w_cnt_nx = '0;
                    if (w_redir_hit) begin
                        w_redir_pend_nx = 1'b0;
                        w_fetch_pc_nx   = w_redir_tgt;
                        w_addr_nx       = w_redir_tgt;
                    end else begin
                        w_inst_nx  = 32'd0;
                        w_pc_nx    = r_fetch_pc;
                        w_vld_nx   = 1'b1;
                        w_err_nx   = 1'b1;
                        w_req_nx   = 1'b0;
                        w_state_nx = S_HOLD;
                    end
                end
`endif
            end
            S_HOLD: begin
                if (!stall_i) begin
                    w_state_nx    = S_REQ;
                    w_fetch_pc_nx = w_sel_pc;
                    w_addr_nx     = w_sel_pc;
                    w_req_nx      = 1'b1;
                    w_inst_nx     = 32'd0;
                    w_vld_nx      = 1'b0;
`ifdef IF_TIMEOUT_EN
                    w_err_nx      = 1'b0;
`endif
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= 32'd0;
            r_pc         <= 32'd0;
            r_inst       <= 32'd0;
            r_vld        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_fetch_pc   <= w_fetch_pc_nx;
            r_redir_pend <= w_redir_pend_nx;
            r_req        <= w_req_nx;
            r_addr       <= w_addr_nx;
            r_pc         <= w_pc_nx;
            r_inst       <= w_inst_nx;
            r_vld        <= w_vld_nx;
        end
    end

    // Redirect target is only meaningful while r_redir_pend is set.
    always_ff @(posedge clk) begin
        r_redir_pc <= w_redir_pc_nx;
    end

`ifdef IF_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_err <= w_err_nx;
        end
    end
    assign fetch_err = r_err;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_vld;

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch: sequential fetch, wait states, jump/exception
// redirects, stall, PC wrap, timeout (or indefinite wait), and reset in the middle of REQ.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jCe;
    logic [31:0] jAddr;
    logic        excpt;
    logic [31:0] ejpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;

    int n_chk;
    int n_err;

    if_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .jCe        (jCe),
        .jAddr      (jAddr),
        .excpt      (excpt),
        .ejpc       (ejpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting in REQ at exp_addr: hold ack low for 'waits' cycles, then ack with 'word'.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int waits);
        chk("req_on", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_vld", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold_vld", {31'd0, inst_valid}, 32'd1);
        chk("hold_pc", pc, exp_addr);
        chk("hold_inst", inst, word);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_err", {31'd0, fetch_err}, 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b1;
        stall_i    = 1'b0;
        jCe        = 1'b0;
        jAddr      = 32'd0;
        excpt      = 1'b0;
        ejpc       = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_vld", {31'd0, inst_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);

        // IDLE -> REQ at RESET_PC, then sequential zero-wait and 3-wait fetches
        rst = 1'b0;
        tick();
        do_fetch(32'h0, 32'hAAAA_0001, 0);
        tick();
        chk("seq_vld_lo", {31'd0, inst_valid}, 32'd0);
        chk("seq_inst_nop", inst, 32'd0);
        do_fetch(32'h4, 32'hBBBB_0002, 3);
        tick();
        do_fetch(32'h8, 32'hCCCC_0003, 0);
        tick();
        do_fetch(32'hC, 32'hDDDD_0004, 0);
        tick();
        do_fetch(32'h10, 32'hEEEE_0005, 0);

        // Jump target with low bits forced to zero
        jCe   = 1'b1;
        jAddr = 32'h43;
        tick();
        jCe   = 1'b0;
        chk("jmp_addr", imem_addr, 32'h40);
        do_fetch(32'h40, 32'h1111_0006, 0);

        // Exception beats a simultaneous jump
        jCe   = 1'b1;
        jAddr = 32'h43;
        excpt = 1'b1;
        ejpc  = 32'h82;
        tick();
        jCe   = 1'b0;
        excpt = 1'b0;
        chk("exc_prio_addr", imem_addr, 32'h80);

        // jCe is ignored while in REQ
        jCe   = 1'b1;
        jAddr = 32'h200;
        tick();
        jCe   = 1'b0;
        chk("jce_in_req", imem_addr, 32'h80);
        do_fetch(32'h80, 32'h2222_0007, 0);

        // Stall holds everything for 5 cycles, even with a jump pending
        stall_i = 1'b1;
        jCe     = 1'b1;
        jAddr   = 32'h300;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", pc, 32'h80);
            chk("stall_inst", inst, 32'h2222_0007);
            chk("stall_vld", {31'd0, inst_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        jCe     = 1'b0;
        stall_i = 1'b0;
        tick();
        chk("after_stall_addr", imem_addr, 32'h84);

        // Exception during REQ: outstanding ack discarded, refetch at the target
        excpt = 1'b1;
        ejpc  = 32'h100;
        tick();
        excpt = 1'b0;
        chk("excreq_req", {31'd0, imem_req}, 32'd1);
        chk("excreq_addr", imem_addr, 32'h84);
        tick();
        chk("excreq_addr2", imem_addr, 32'h84);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_0008;
        tick();
        imem_ack   = 1'b0;
        chk("excreq_vld", {31'd0, inst_valid}, 32'd0);
        chk("excreq_redir", imem_addr, 32'h100);
        chk("excreq_req2", {31'd0, imem_req}, 32'd1);
        do_fetch(32'h100, 32'h4444_0009, 0);

        // PC wrap from 0xFFFF_FFFC
        excpt = 1'b1;
        ejpc  = 32'hFFFF_FFFC;
        tick();
        excpt = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'h5555_000A, 0);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);

`ifdef IF_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("tmo_wait_req", {31'd0, imem_req}, 32'd1);
            chk("tmo_wait_err", {31'd0, fetch_err}, 32'd0);
        end
        tick();
        chk("tmo_req", {31'd0, imem_req}, 32'd0);
        chk("tmo_vld", {31'd0, inst_valid}, 32'd1);
        chk("tmo_inst", inst, 32'd0);
        chk("tmo_pc", pc, 32'd0);
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        tick();
        chk("tmo_err_clr", {31'd0, fetch_err}, 32'd0);
        chk("tmo_next_addr", imem_addr, 32'h4);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("noack_req", {31'd0, imem_req}, 32'd1);
            chk("noack_err", {31'd0, fetch_err}, 32'd0);
        end
        chk("noack_addr", imem_addr, 32'h0);
        chk("noack_vld", {31'd0, inst_valid}, 32'd0);
`endif

        // Reset in the middle of REQ; a late ack while in IDLE is ignored
        rst = 1'b1;
        tick();
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_vld", {31'd0, inst_valid}, 32'd0);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h6666_000B;
        tick();
        imem_ack   = 1'b0;
        chk("late_ack_vld", {31'd0, inst_valid}, 32'd0);
        do_fetch(32'h0, 32'h7777_000C, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
